fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter / instruction-fetch sequencer for the 3BC 9-bit processor.
- Drives the instruction ROM address and consumes the decoder's control outputs: Ack (halt), OffsetSrc (branch offset source), and the ALU branch-taken condition.
- Owns the Start/Done handshake with the testbench, plus a run-cycle counter used for performance checks.

Parameters:
- PC_W, 10, PC / instruction-ROM address width.
- OFF_W, 8, branch offset width; two's-complement, sign-extended to PC_W.
- CNT_W, 16, width of the run-cycle counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  testbench request; level-sensitive, high = hold and reload PC.
- Ack  in  1  decoder halt flag for the current instruction (all-ones opcode).
- BranchTaken  in  1  current instruction is a branch whose condition is satisfied.
- OffsetSrc  in  1  1 = offset from RegOffset (register branch), 0 = offset from LutOffset.
- RegOffset  in  OFF_W  offset read from the register file.
- LutOffset  in  OFF_W  offset from the branch LUT.
- PC  out  PC_W  instruction ROM address.
- Running  out  1  high while instructions are being executed.
- Done  out  1  program finished; held until the next Start.
- CycleCount  out  CNT_W  number of RUN cycles since the last Start.

Behaviour:
- States: IDLE, LOAD, RUN, HALT.
- Reset (async, Reset_n=0):
  - state=IDLE, PC=0, Running=0, Done=0, CycleCount=0.
  - Applies immediately, including mid-RUN; no partial update survives.
- IDLE: Start=1 -> LOAD. Otherwise stay; PC frozen.
- LOAD (Start high):
  - PC=0, CycleCount=0, Done=0, Running=0.
  - Start=0 -> RUN next edge.
- RUN: Running=1, CycleCount increments each cycle and saturates at all-ones. PC update per edge, in priority order:
  1. Start=1 -> LOAD, PC=0. Overrides everything.
  2. Ack=1 -> HALT. PC unchanged; the Ack instruction is not advanced past. Done=1 from the next cycle.
  3. BranchTaken=1 -> PC = PC + sext(OffsetSrc ? RegOffset : LutOffset). The offset is relative to the branch's own PC.
  4. Otherwise PC = PC + 1.
- Arithmetic is modulo 2^PC_W, so wrap-around in either direction is legal and silent (e.g. PC=1023, +1 -> 0).
- Ack and BranchTaken both high: Ack wins.
- Offset 0 with BranchTaken: PC stays. This is a legal spin loop; CycleCount keeps counting.
- HALT:
  - Done=1, Running=0, PC and CycleCount frozen.
  - Ack and BranchTaken are ignored.
  - Start=1 -> LOAD, and Done drops the cycle after Start is sampled.
- Outputs are registered, except Running and Done, which are decoded from the state register. There is no combinational path from any input to any output.
- Latency: the first instruction address (0) is presented during the LOAD cycles. The first RUN edge advances PC based on instruction 0's decode.

Decomposition:
- Shared package definitions:
  - enum fetch_state_t {IDLE, LOAD, RUN, HALT};
  - constants kPC_W=10, kOFF_W=8.
- Offset mux plus sign-extend-and-add is natural as sub-module branch_target (combinational: PC, OffsetSrc, RegOffset, LutOffset -> target).
- The FSM, PC register and counter stay in fetch_unit.

Test Plan:
- Reset/start: Reset_n low mid-run at PC=37 -> PC=0, Done=0, CycleCount=0 immediately. Then Start high 2 cycles and low -> PC sequence 0, 1, 2, 3; Running=1.
- LUT branch: PC=20, BranchTaken=1, OffsetSrc=0, LutOffset=8'hF6 (-10) -> next PC=10. LutOffset=8'd5 -> next PC=25.
- Register branch and wrap: PC=3, OffsetSrc=1, RegOffset=8'hFB (-5) -> PC=1022. PC=1023 with no branch -> PC=0.
- Halt: Ack=1 at PC=50 with BranchTaken=1 simultaneously -> state HALT, PC stays 50, Done=1 next cycle. CycleCount frozen across 10 idle cycles.
- Restart from HALT: Start=1 for 1 cycle -> Done=0, PC=0, CycleCount=0. Second program runs; CycleCount equals its instruction count.
- Saturation: with CNT_W overridden to 4, 20 RUN cycles -> CycleCount=15 and holds.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and default widths for the 3BC fetch sequencer.
package fetch_unit_pkg;

  localparam int kPC_W  = 10;
  localparam int kOFF_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_branch_target.sv
// Branch target: selects the offset source, sign-extends it and adds it to
// the branch instruction's own PC. Purely combinational.
module branch_target
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = kPC_W,
  parameter int OFF_W = kOFF_W
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_offset_src,
  input  logic [OFF_W-1:0] i_reg_offset,
  input  logic [OFF_W-1:0] i_lut_offset,
  output logic [PC_W-1:0]  o_target
);

  logic [OFF_W-1:0] w_offset;
  logic [PC_W-1:0]  w_offset_sext;

  assign w_offset      = i_offset_src ? i_reg_offset : i_lut_offset;
  // Two's-complement offset; the add wraps modulo 2^PC_W by construction.
  assign w_offset_sext = {{(PC_W-OFF_W){w_offset[OFF_W-1]}}, w_offset};
  assign o_target      = i_pc + w_offset_sext;

endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer: IDLE -> LOAD -> RUN -> HALT with the
// Start/Done handshake and a saturating run-cycle counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = kPC_W,
  parameter int OFF_W = kOFF_W,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Ack,
  input  logic             BranchTaken,
  input  logic             OffsetSrc,
  input  logic [OFF_W-1:0] RegOffset,
  input  logic [OFF_W-1:0] LutOffset,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       o_dbg_state
);

  // Handshake: Start is a level; while high the sequencer holds in LOAD with
  // PC=0. Done stays high in HALT until Start is sampled high again.

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;

  fetch_state_t     w_state_nxt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0] w_cnt_inc;

  branch_target #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_branch_target (
    .i_pc         (r_pc),
    .i_offset_src (OffsetSrc),
    .i_reg_offset (RegOffset),
    .i_lut_offset (LutOffset),
    .o_target     (w_target)
  );

  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_state_nxt = LOAD;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
      LOAD: begin
        w_pc_nxt  = '0;
        w_cnt_nxt = '0;
        if (!Start) w_state_nxt = RUN;
      end
      RUN: begin
        if (Start) begin
          w_state_nxt = LOAD;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end else begin
          // The halting instruction still counts as an executed cycle.
          w_cnt_nxt = w_cnt_inc;
          if (Ack)              w_state_nxt = HALT;
          else if (BranchTaken) w_pc_nxt    = w_target;
          else                  w_pc_nxt    = w_pc_inc;
        end
      end
      HALT: begin
        if (Start) begin
          w_state_nxt = LOAD;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign PC          = r_pc;
  assign CycleCount  = r_cnt;
  assign Running     = (r_state == RUN);
  assign Done        = (r_state == HALT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// program-level reference model; a second instance uses a 4-bit counter.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ack;
  logic       bt;
  logic       osrc;
  logic [7:0] reg_off;
  logic [7:0] lut_off;

  logic [9:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] cnt;
  logic [1:0]  dbg_state;

  logic [9:0]  pc_s;
  logic        running_s;
  logic        done_s;
  logic [3:0]  cnt_s;
  logic [1:0]  dbg_state_s;

  int checks;
  int failures;

  // Reference model: program phase, PC and cycle counts as plain integers.
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_HALT = 3;
  int m_phase;
  int m_pc;
  int m_cnt;
  int m_cnt4;

  fetch_unit u_dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Ack(ack), .BranchTaken(bt),
    .OffsetSrc(osrc), .RegOffset(reg_off), .LutOffset(lut_off),
    .PC(pc), .Running(running), .Done(done), .CycleCount(cnt),
    .o_dbg_state(dbg_state)
  );

  fetch_unit #(.CNT_W(4)) u_sat (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Ack(ack), .BranchTaken(bt),
    .OffsetSrc(osrc), .RegOffset(reg_off), .LutOffset(lut_off),
    .PC(pc_s), .Running(running_s), .Done(done_s), .CycleCount(cnt_s),
    .o_dbg_state(dbg_state_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_pc    = 0;
    m_cnt   = 0;
    m_cnt4  = 0;
  endtask

  task automatic model_restart();
    m_phase = PH_LOAD;
    m_pc    = 0;
    m_cnt   = 0;
    m_cnt4  = 0;
  endtask

  task automatic model_edge();
    int off;
    if (m_phase == PH_RUN) begin
      if (start) model_restart();
      else begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
        m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
        if (ack) m_phase = PH_HALT;
        else if (bt) begin
          off  = osrc ? int'($signed(reg_off)) : int'($signed(lut_off));
          m_pc = (m_pc + off + 1024) % 1024;
        end else m_pc = (m_pc + 1) % 1024;
      end
    end else if (m_phase == PH_LOAD) begin
      m_pc = 0; m_cnt = 0; m_cnt4 = 0;
      if (!start) m_phase = PH_RUN;
    end else if (start) model_restart();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_inputs();
    start = 0; ack = 0; bt = 0; osrc = 0; reg_off = 8'd0; lut_off = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0 || cnt !== 16'd0) begin
      failures++; $display("FAIL reset_state got pc=%0d run=%0b done=%0b cnt=%0d exp 0/0/0/0", pc, running, done, cnt);
    end
    rst_n = 1;
    tick(); tick();
    checks++; if (pc !== 10'd0 || running !== 1'b0) begin
      failures++; $display("FAIL idle_frozen got pc=%0d run=%0b exp pc=0 run=0", pc, running);
    end
    start = 1; tick(); start = 0; tick();
    bt = 1; lut_off = 8'd37; tick(); bt = 0;
    checks++; if (pc !== 10'd37) begin
      failures++; $display("FAIL reach_37 got=%0d exp=37", pc);
    end
    tick();
    #2; rst_n = 0; #1;
    model_reset();
    checks++; if (pc !== 10'd0 || done !== 1'b0 || cnt !== 16'd0 || running !== 1'b0) begin
      failures++; $display("FAIL async_reset got pc=%0d done=%0b cnt=%0d run=%0b exp 0/0/0/0", pc, done, cnt, running);
    end
    #1; rst_n = 1;
  endtask

  task automatic test_start_seq();
    int exp_seq[4] = '{0, 1, 2, 3};
    start = 1; tick(); tick();
    checks++; if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL load_hold got pc=%0d run=%0b done=%0b exp 0/0/0", pc, running, done);
    end
    start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc !== 10'(exp_seq[i]) || running !== 1'b1) begin
        failures++; $display("FAIL start_seq[%0d] got pc=%0d run=%0b exp pc=%0d run=1", i, pc, running, exp_seq[i]);
      end
    end
  endtask

  task automatic test_lut_branch();
    bt = 1; osrc = 0;
    lut_off = 8'd17; tick();
    checks++; if (pc !== 10'd20) begin failures++; $display("FAIL lut_to_20 got=%0d exp=20", pc); end
    lut_off = 8'hF6; tick();
    checks++; if (pc !== 10'd10) begin failures++; $display("FAIL lut_back10 got=%0d exp=10", pc); end
    lut_off = 8'd10; tick();
    lut_off = 8'd5; tick();
    checks++; if (pc !== 10'd25) begin failures++; $display("FAIL lut_fwd5 got=%0d exp=25", pc); end
    lut_off = 8'd0; tick();
    checks++; if (pc !== 10'd25 || cnt !== 16'(m_cnt)) begin
      failures++; $display("FAIL spin_loop got pc=%0d cnt=%0d exp pc=25 cnt=%0d", pc, cnt, m_cnt);
    end
    bt = 0;
  endtask

  task automatic test_reg_branch_wrap();
    bt = 1; osrc = 1;
    reg_off = 8'hEA; lut_off = 8'd99; tick();
    checks++; if (pc !== 10'd3) begin failures++; $display("FAIL reg_to_3 got=%0d exp=3", pc); end
    reg_off = 8'hFB; tick();
    checks++; if (pc !== 10'd1022) begin failures++; $display("FAIL reg_wrap_neg got=%0d exp=1022", pc); end
    bt = 0; tick();
    checks++; if (pc !== 10'd1023) begin failures++; $display("FAIL inc_1023 got=%0d exp=1023", pc); end
    tick();
    checks++; if (pc !== 10'd0) begin failures++; $display("FAIL inc_wrap got=%0d exp=0", pc); end
    osrc = 0; lut_off = 8'd0; reg_off = 8'd0;
  endtask

  task automatic test_halt();
    logic [15:0] held;
    bt = 1; osrc = 0; lut_off = 8'd50; tick();
    checks++; if (pc !== 10'd50) begin failures++; $display("FAIL reach_50 got=%0d exp=50", pc); end
    ack = 1; lut_off = 8'd7; tick();
    checks++; if (pc !== 10'd50 || done !== 1'b1 || running !== 1'b0) begin
      failures++; $display("FAIL halt_enter got pc=%0d done=%0b run=%0b exp 50/1/0", pc, done, running);
    end
    held = 16'(m_cnt);
    for (int i = 0; i < 10; i++) begin
      ack = 1'($urandom_range(0, 1)); bt = 1'($urandom_range(0, 1));
      lut_off = 8'($urandom); reg_off = 8'($urandom); osrc = 1'($urandom_range(0, 1));
      tick();
      checks++; if (pc !== 10'd50 || cnt !== held || done !== 1'b1) begin
        failures++; $display("FAIL halt_frozen[%0d] got pc=%0d cnt=%0d done=%0b exp 50/%0d/1", i, pc, cnt, done, held);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_restart();
    start = 1; tick();
    checks++; if (done !== 1'b0 || pc !== 10'd0 || cnt !== 16'd0) begin
      failures++; $display("FAIL restart_load got done=%0b pc=%0d cnt=%0d exp 0/0/0", done, pc, cnt);
    end
    start = 0; tick();
    for (int i = 0; i < 5; i++) tick();
    ack = 1; tick(); ack = 0;
    checks++; if (cnt !== 16'd6 || pc !== 10'd5 || done !== 1'b1) begin
      failures++; $display("FAIL second_prog got cnt=%0d pc=%0d done=%0b exp 6/5/1", cnt, pc, done);
    end
  endtask

  task automatic test_saturation();
    start = 1; tick(); start = 0; tick();
    for (int i = 0; i < 20; i++) tick();
    checks++; if (cnt_s !== 4'd15 || cnt !== 16'd20 || pc_s !== 10'd20) begin
      failures++; $display("FAIL saturate got cnt4=%0d cnt=%0d pc=%0d exp 15/20/20", cnt_s, cnt, pc_s);
    end
    tick(); tick();
    checks++; if (cnt_s !== 4'd15) begin failures++; $display("FAIL saturate_hold got=%0d exp=15", cnt_s); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 39) == 0);
      ack     = ($urandom_range(0, 15) == 0);
      bt      = ($urandom_range(0, 2) == 0);
      osrc    = 1'($urandom_range(0, 1));
      reg_off = 8'($urandom);
      lut_off = 8'($urandom);
      tick();
      checks++; if (pc !== 10'(m_pc) || running !== (m_phase == PH_RUN) || done !== (m_phase == PH_HALT) ||
                    cnt !== 16'(m_cnt) || cnt_s !== 4'(m_cnt4)) begin
        failures++;
        $display("FAIL random[%0d] got pc=%0d run=%0b done=%0b cnt=%0d cnt4=%0d exp pc=%0d run=%0b done=%0b cnt=%0d cnt4=%0d",
                 i, pc, running, done, cnt, cnt_s, m_pc, m_phase == PH_RUN, m_phase == PH_HALT, m_cnt, m_cnt4);
      end
    end
    quiet_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_start_seq();
    test_lut_branch();
    test_reg_branch_wrap();
    test_halt();
    test_restart();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
